// File: rtl/sample_framer.sv
// Packetizes 14-bit samples from a FIFO into sync/seq/payload/checksum frames
// and issues them one byte at a time to a UART transmitter.
module sample_framer #(
  parameter int unsigned DATA_SIZE  = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FRAME_LEN  = 32,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [DATA_SIZE-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_next,
  input  logic                 i_tx_ready,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  output logic                 o_frame_done,
  output logic                 o_overflow,
  output logic [7:0]           o_seq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_SEQ   = 3'd2;
  localparam logic [2:0] ST_LO    = 3'd3;
  localparam logic [2:0] ST_HI    = 3'd4;
  localparam logic [2:0] ST_CKSUM = 3'd5;

  logic [13:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          next_q, next_d;
  logic          ovf_q, ovf_d;

  logic [2:0]    state_q, state_d;
  logic [1:0]    guard_q, guard_d;
  logic [7:0]    sent_q, sent_d;
  logic [5:0]    hi_q, hi_d;
  logic [7:0]    cksum_q, cksum_d;
  logic [7:0]    seq_q, seq_d;
  logic          start_q, start_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;

  logic          empty, full, can_issue, pop, wr_en;
  logic [13:0]   head;

  // Sample bits above the 14-bit payload are intentionally discarded.
  logic unused_data_hi;
  assign unused_data_hi = ^i_data[DATA_SIZE-1:14];

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign can_issue = i_tx_ready && (guard_q == '0);
  assign pop       = (state_q == ST_LO) && can_issue && !empty;
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign wr_en     = i_valid && (!full || pop);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(pop);
    next_d   = (count_d <= CW'(FIFO_DEPTH - 2));
    ovf_d    = ovf_q || (i_valid && !wr_en);
  end

  always_comb begin
    state_d = state_q;
    sent_d  = sent_q;
    hi_d    = hi_q;
    cksum_d = cksum_q;
    seq_d   = seq_q;
    start_d = 1'b0;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (can_issue) begin
          start_d = 1'b1;
          data_d  = SYNC_BYTE;
          cksum_d = '0;
          state_d = ST_SEQ;
        end
      end
      ST_SEQ: begin
        if (can_issue) begin
          start_d = 1'b1;
          data_d  = seq_q;
          cksum_d = cksum_q ^ seq_q;
          sent_d  = '0;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (pop) begin
          start_d = 1'b1;
          data_d  = head[7:0];
          hi_d    = head[13:8];
          cksum_d = cksum_q ^ head[7:0];
          sent_d  = sent_q + 8'd1;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (can_issue) begin
          start_d = 1'b1;
          data_d  = {2'b00, hi_q};
          cksum_d = cksum_q ^ {2'b00, hi_q};
          state_d = (sent_q < 8'(FRAME_LEN)) ? ST_LO : ST_CKSUM;
        end
      end
      ST_CKSUM: begin
        if (can_issue) begin
          start_d = 1'b1;
          data_d  = cksum_q;
          done_d  = 1'b1;
          seq_d   = seq_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Ready is ignored for two cycles after each pulse while the UART deasserts it.
    if (start_d)             guard_d = 2'd2;
    else if (guard_q != '0)  guard_d = guard_q - 2'd1;
    else                     guard_d = '0;
  end

  always_ff @(posedge i_clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_data[13:0];
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      next_q   <= 1'b1;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      guard_q  <= '0;
      sent_q   <= '0;
      hi_q     <= '0;
      cksum_q  <= '0;
      seq_q    <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      next_q   <= next_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      guard_q  <= guard_d;
      sent_q   <= sent_d;
      hi_q     <= hi_d;
      cksum_q  <= cksum_d;
      seq_q    <= seq_d;
      start_q  <= start_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  assign o_next       = next_q;
  assign o_overflow   = ovf_q;
  assign o_tx_start   = start_q;
  assign o_tx_data    = data_q;
  assign o_frame_done = done_q;
  assign o_seq        = seq_q;

endmodule
